// File: rtl/io_device_ctrl.sv
// io_device_ctrl: peripheral side of the DIR/DOR/SR/CR I/O port.
// Input path captures board words and flags them ready until the CPU acks;
// output path holds each DOR word on the display for HOLD_CYCLES cycles.
// Optional build macro IO_IN_FIFO_EN replaces the single input register
// with a FIFO_DEPTH-entry FIFO.
//
// Handshake semantics: dev_in_strobe, in_ack, dor_write and err_clr are
// single-cycle pulses sampled on the rising clock edge; is_ready_1 and
// is_ready_2 are level status flags reflecting registered state, so a
// pulse takes effect on the edge it is sampled and is visible one cycle later.
module io_device_ctrl #(
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dev_in_data,
  input  logic              dev_in_strobe,
  input  logic              in_ack,
  output logic              is_ready_1,
  output logic [DATA_W-1:0] data_input,
  input  logic              dor_write,
  input  logic [DATA_W-1:0] data_output,
  output logic              is_ready_2,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_busy,
  input  logic              err_clr,
  output logic              in_overrun,
  output logic              out_drop
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  logic overrun_evt;
  logic drop_evt;

`ifdef IO_IN_FIFO_EN
  // ---------------- input path: FIFO ----------------
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wptr, rptr, rptr_p1, fill;
  logic              fifo_empty, fifo_full, push, pop;

  assign fill        = wptr - rptr;
  assign rptr_p1     = rptr + ONE_L;
  assign fifo_empty  = (wptr == rptr);
  assign fifo_full   = (fill == DEPTH_L);
  // When full, a push is only allowed if the same edge pops an entry.
  assign pop         = in_ack && !fifo_empty;
  assign push        = dev_in_strobe && (!fifo_full || in_ack);
  assign overrun_evt = dev_in_strobe && fifo_full && !in_ack;
  assign is_ready_1  = !fifo_empty;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= dev_in_data;
  end

  // Pointers and the registered head word presented on data_input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      data_input <= '0;
    end else begin
      if (push) wptr <= wptr + ONE_L;
      if (pop)  rptr <= rptr_p1;
      if (push && fifo_empty) begin
        data_input <= dev_in_data;
      end else if (pop) begin
        // With a single entry left, the next head is whatever is pushed now.
        if (fill == ONE_L) begin
          if (push) data_input <= dev_in_data;
        end else begin
          data_input <= mem[rptr_p1[AW-1:0]];
        end
      end
    end
  end
`else
  // ---------------- input path: single register ----------------
  typedef enum logic {IN_EMPTY, IN_FULL} in_state_t;
  in_state_t         in_state, in_state_nxt;
  logic [DATA_W-1:0] data_input_nxt;

  // Input FSM state and data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state   <= IN_EMPTY;
      data_input <= '0;
    end else begin
      in_state   <= in_state_nxt;
      data_input <= data_input_nxt;
    end
  end

  // Input FSM next state: ack+strobe together reloads and stays full.
  always_comb begin
    in_state_nxt   = in_state;
    data_input_nxt = data_input;
    overrun_evt    = 1'b0;
    case (in_state)
      IN_EMPTY: begin
        if (dev_in_strobe) begin
          data_input_nxt = dev_in_data;
          in_state_nxt   = IN_FULL;
        end
      end
      IN_FULL: begin
        if (dev_in_strobe && in_ack) begin
          data_input_nxt = dev_in_data;
        end else if (in_ack) begin
          in_state_nxt = IN_EMPTY;
        end else if (dev_in_strobe) begin
          overrun_evt = 1'b1;
        end
      end
      default: in_state_nxt = IN_EMPTY;
    endcase
  end

  assign is_ready_1 = (in_state == IN_FULL);
`endif

  // ---------------- output path ----------------
  typedef enum logic {OUT_IDLE, OUT_HOLD} out_state_t;
  out_state_t        out_state, out_state_nxt;
  logic [7:0]        hold_cnt, hold_cnt_nxt;
  logic [DATA_W-1:0] disp_data_nxt;

  // Output FSM state, hold counter and display register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state <= OUT_IDLE;
      hold_cnt  <= '0;
      disp_data <= '0;
    end else begin
      out_state <= out_state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      disp_data <= disp_data_nxt;
    end
  end

  // Output FSM next state: counter loaded with HOLD_CYCLES-1 so busy lasts HOLD_CYCLES.
  always_comb begin
    out_state_nxt = out_state;
    hold_cnt_nxt  = hold_cnt;
    disp_data_nxt = disp_data;
    drop_evt      = 1'b0;
    case (out_state)
      OUT_IDLE: begin
        if (dor_write) begin
          disp_data_nxt = data_output;
          hold_cnt_nxt  = HOLD_INIT;
          out_state_nxt = OUT_HOLD;
        end
      end
      OUT_HOLD: begin
        drop_evt = dor_write;
        if (hold_cnt == 8'd0) begin
          out_state_nxt = OUT_IDLE;
        end else begin
          hold_cnt_nxt = hold_cnt - 8'd1;
        end
      end
      default: out_state_nxt = OUT_IDLE;
    endcase
  end

  assign is_ready_2 = (out_state == OUT_IDLE);
  assign disp_busy  = (out_state == OUT_HOLD);

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_overrun <= 1'b0;
      out_drop   <= 1'b0;
    end else begin
      if (overrun_evt)  in_overrun <= 1'b1;
      else if (err_clr) in_overrun <= 1'b0;
      if (drop_evt)     out_drop   <= 1'b1;
      else if (err_clr) out_drop   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_device_ctrl.sv
// Directed testbench for io_device_ctrl (HOLD_CYCLES=4, FIFO_DEPTH=4).
module tb_io_device_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  dev_in_data;
  logic          dev_in_strobe;
  logic          in_ack;
  logic          is_ready_1;
  logic [W-1:0]  data_input;
  logic          dor_write;
  logic [W-1:0]  data_output;
  logic          is_ready_2;
  logic [W-1:0]  disp_data;
  logic          disp_busy;
  logic          err_clr;
  logic          in_overrun;
  logic          out_drop;

  int n_checks = 0;
  int n_fail   = 0;

  io_device_ctrl #(.DATA_W(W), .HOLD_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .dev_in_data(dev_in_data), .dev_in_strobe(dev_in_strobe), .in_ack(in_ack),
    .is_ready_1(is_ready_1), .data_input(data_input),
    .dor_write(dor_write), .data_output(data_output),
    .is_ready_2(is_ready_2), .disp_data(disp_data), .disp_busy(disp_busy),
    .err_clr(err_clr), .in_overrun(in_overrun), .out_drop(out_drop)
  );

  // Clock: rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic idle_inputs();
    dev_in_strobe = 1'b0;
    in_ack        = 1'b0;
    dor_write     = 1'b0;
    err_clr       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dev_in_data = '0;
    data_output = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    if (is_ready_1 !== 1'b0) begin $display("FAIL reset_rdy1: got %b want 0", is_ready_1); n_fail++; end
    n_checks++;
    if (data_input !== 32'h0) begin $display("FAIL reset_din: got %h want 0", data_input); n_fail++; end
    n_checks++;
    if (is_ready_2 !== 1'b1) begin $display("FAIL reset_rdy2: got %b want 1", is_ready_2); n_fail++; end
    n_checks++;
    if (disp_busy !== 1'b0 || disp_data !== 32'h0) begin
      $display("FAIL reset_disp: got busy=%b data=%h want 0/0", disp_busy, disp_data); n_fail++;
    end
    n_checks++;
    if (in_overrun !== 1'b0 || out_drop !== 1'b0) begin
      $display("FAIL reset_flags: got %b%b want 00", in_overrun, out_drop); n_fail++;
    end
    n_checks++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_input_handshake();
    dev_in_data = 32'h0000_00A5; dev_in_strobe = 1'b1;
    @(negedge clk); dev_in_strobe = 1'b0;
    if (is_ready_1 !== 1'b1 || data_input !== 32'h0000_00A5) begin
      $display("FAIL hs_load: got rdy=%b data=%h want 1/000000a5", is_ready_1, data_input); n_fail++;
    end
    n_checks++;
    in_ack = 1'b1;
    @(negedge clk); in_ack = 1'b0;
    if (is_ready_1 !== 1'b0) begin $display("FAIL hs_ack: got rdy=%b want 0", is_ready_1); n_fail++; end
    n_checks++;
    in_ack = 1'b1;
    @(negedge clk); in_ack = 1'b0;
    if (is_ready_1 !== 1'b0 || data_input !== 32'h0000_00A5 || in_overrun !== 1'b0) begin
      $display("FAIL hs_ack_empty: got rdy=%b data=%h ovr=%b want 0/000000a5/0",
               is_ready_1, data_input, in_overrun); n_fail++;
    end
    n_checks++;
  endtask

`ifndef IO_IN_FIFO_EN
  task automatic test_overrun();
    dev_in_data = 32'h11; dev_in_strobe = 1'b1;
    @(negedge clk);
    dev_in_data = 32'h22;
    @(negedge clk); dev_in_strobe = 1'b0;
    if (data_input !== 32'h11 || in_overrun !== 1'b1 || is_ready_1 !== 1'b1) begin
      $display("FAIL ovr_drop: got data=%h ovr=%b rdy=%b want 11/1/1", data_input, in_overrun, is_ready_1);
      n_fail++;
    end
    n_checks++;
    dev_in_data = 32'h33; dev_in_strobe = 1'b1; in_ack = 1'b1;
    @(negedge clk); dev_in_strobe = 1'b0; in_ack = 1'b0;
    if (data_input !== 32'h33 || is_ready_1 !== 1'b1) begin
      $display("FAIL ovr_ack_load: got data=%h rdy=%b want 33/1", data_input, is_ready_1); n_fail++;
    end
    n_checks++;
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    if (in_overrun !== 1'b0) begin $display("FAIL ovr_clr: got %b want 0", in_overrun); n_fail++; end
    n_checks++;
    in_ack = 1'b1;
    @(negedge clk); in_ack = 1'b0;
    if (is_ready_1 !== 1'b0) begin $display("FAIL ovr_drain: got rdy=%b want 0", is_ready_1); n_fail++; end
    n_checks++;
  endtask
`else
  task automatic test_fifo();
    for (int k = 1; k <= 5; k++) begin
      dev_in_data = W'(k); dev_in_strobe = 1'b1;
      @(negedge clk);
    end
    dev_in_strobe = 1'b0;
    if (in_overrun !== 1'b1 || is_ready_1 !== 1'b1) begin
      $display("FAIL fifo_ovr: got ovr=%b rdy=%b want 1/1", in_overrun, is_ready_1); n_fail++;
    end
    n_checks++;
    for (int k = 1; k <= 4; k++) begin
      if (data_input !== W'(k) || is_ready_1 !== 1'b1) begin
        $display("FAIL fifo_pop%0d: got data=%h rdy=%b want %h/1", k, data_input, is_ready_1, W'(k));
        n_fail++;
      end
      n_checks++;
      in_ack = 1'b1;
      @(negedge clk); in_ack = 1'b0;
    end
    if (is_ready_1 !== 1'b0) begin $display("FAIL fifo_empty: got rdy=%b want 0", is_ready_1); n_fail++; end
    n_checks++;
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    if (in_overrun !== 1'b0) begin $display("FAIL fifo_clr: got %b want 0", in_overrun); n_fail++; end
    n_checks++;
  endtask
`endif

  task automatic test_output_hold();
    data_output = 32'hDEAD_BEEF; dor_write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dor_write   = (i == 1);
      data_output = 32'h0000_1234;
      if (disp_busy !== (i < 4) || is_ready_2 !== !(i < 4) || disp_data !== 32'hDEAD_BEEF) begin
        $display("FAIL hold_c%0d: got busy=%b rdy2=%b disp=%h want %b/%b/deadbeef",
                 i, disp_busy, is_ready_2, disp_data, (i < 4), !(i < 4));
        n_fail++;
      end
      n_checks++;
    end
    if (out_drop !== 1'b1) begin $display("FAIL hold_drop: got %b want 1", out_drop); n_fail++; end
    n_checks++;
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    if (out_drop !== 1'b0) begin $display("FAIL hold_clr: got %b want 0", out_drop); n_fail++; end
    n_checks++;
  endtask

  task automatic test_concurrency();
    dev_in_data = 32'h7; dev_in_strobe = 1'b1;
    data_output = 32'h9; dor_write = 1'b1;
    @(negedge clk);
    dev_in_strobe = 1'b0;
    data_output = 32'h66;
    @(negedge clk);
    if (out_drop !== 1'b1) begin $display("FAIL conc_drop: got %b want 1", out_drop); n_fail++; end
    n_checks++;
    data_output = 32'h55; err_clr = 1'b1;
    @(negedge clk); dor_write = 1'b0; err_clr = 1'b0;
    if (data_input !== 32'h7 || is_ready_1 !== 1'b1 || disp_data !== 32'h9) begin
      $display("FAIL conc_data: got din=%h rdy1=%b disp=%h want 7/1/9", data_input, is_ready_1, disp_data);
      n_fail++;
    end
    n_checks++;
    if (out_drop !== 1'b1) begin $display("FAIL conc_set_wins: got %b want 1", out_drop); n_fail++; end
    n_checks++;
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    if (out_drop !== 1'b0) begin $display("FAIL conc_clr: got %b want 0", out_drop); n_fail++; end
    n_checks++;
    repeat (4) @(negedge clk);
    if (is_ready_2 !== 1'b1) begin $display("FAIL conc_idle: got rdy2=%b want 1", is_ready_2); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reset_midop();
    in_ack = 1'b1;
    @(negedge clk); in_ack = 1'b0;
    dev_in_data = 32'hAA; dev_in_strobe = 1'b1;
    data_output = 32'h55; dor_write = 1'b1;
    @(negedge clk); dev_in_strobe = 1'b0; dor_write = 1'b0;
    // Hold counter is now 3 and an input word is pending.
    if (is_ready_1 !== 1'b1 || disp_busy !== 1'b1) begin
      $display("FAIL mid_setup: got rdy1=%b busy=%b want 1/1", is_ready_1, disp_busy); n_fail++;
    end
    n_checks++;
    #2 rst = 1'b1;
    #1;
    if (is_ready_1 !== 1'b0 || data_input !== 32'h0 || is_ready_2 !== 1'b1 || disp_busy !== 1'b0 ||
        disp_data !== 32'h0 || in_overrun !== 1'b0 || out_drop !== 1'b0) begin
      $display("FAIL mid_reset: got rdy1=%b din=%h rdy2=%b busy=%b disp=%h ovr=%b drop=%b",
               is_ready_1, data_input, is_ready_2, disp_busy, disp_data, in_overrun, out_drop);
      n_fail++;
    end
    n_checks++;
    @(negedge clk); rst = 1'b0;
    dev_in_data = 32'hBB; dev_in_strobe = 1'b1;
    @(negedge clk); dev_in_strobe = 1'b0;
    if (is_ready_1 !== 1'b1 || data_input !== 32'hBB) begin
      $display("FAIL post_reset: got rdy1=%b din=%h want 1/bb", is_ready_1, data_input); n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_input_handshake();
`ifndef IO_IN_FIFO_EN
    test_overrun();
`else
    test_fifo();
`endif
    test_output_hold();
    test_concurrency();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_device_ctrl.md
Name: io_device_ctrl

Overview:
Peripheral-side end of the DIR/DOR/SR/CR I/O port. Captures words from a board input source and presents them with an input-ready flag until the CPU-side port acknowledges the read. Accepts words written from DOR, holds each on the display output for a fixed time, and reports output-ready when it can take the next word. Sits between the board switches/LEDs/segments and the CPU I/O interface.

Parameters:
DATA_W, 32, width of every data word.
HOLD_CYCLES, 8, cycles a written word keeps disp_busy high; legal range 1..255.
FIFO_DEPTH, 4, input buffer depth when IO_IN_FIFO_EN is defined; power of 2, at least 2.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous reset, active-high.
dev_in_data  input  DATA_W  word from the board input source.
dev_in_strobe  input  1  one-cycle pulse; dev_in_data is valid in that cycle.
in_ack  input  1  one-cycle pulse; CPU side has consumed data_input.
is_ready_1  output  1  input word available.
data_input  output  DATA_W  current input word; valid while is_ready_1 is high.
dor_write  input  1  one-cycle pulse; data_output is valid in that cycle.
data_output  input  DATA_W  word from DOR.
is_ready_2  output  1  output side idle; a write will be accepted.
disp_data  output  DATA_W  last accepted output word, drives the display.
disp_busy  output  1  hold period in progress.
err_clr  input  1  clears in_overrun and out_drop.
in_overrun  output  1  sticky flag: a strobe arrived while the input buffer was full.
out_drop  output  1  sticky flag: dor_write arrived while is_ready_2 was low.

Behaviour:
- Reset (asynchronous; may assert mid-operation). Outputs take these values immediately:
  - is_ready_1=0, data_input=0, is_ready_2=1, disp_data=0, disp_busy=0, in_overrun=0, out_drop=0.
  - The input FSM goes to IN_EMPTY, the output FSM goes to OUT_IDLE, and the hold counter is cleared.
  - Any pending word is discarded. After reset releases, the next rising edge already operates normally.
- Input FSM, single-register form (IO_IN_FIFO_EN not defined):
  - IN_EMPTY: on dev_in_strobe, register dev_in_data into data_input and move to IN_FULL. is_ready_1 goes high on the following cycle (1-cycle latency).
  - IN_FULL: is_ready_1=1 and data_input is held stable.
    - in_ack alone: return to IN_EMPTY; is_ready_1=0 next cycle.
    - dev_in_strobe alone: word dropped, in_overrun set, data_input unchanged.
    - in_ack and dev_in_strobe in the same cycle: load the new word and stay in IN_FULL. is_ready_1 stays high; no overrun.
  - in_ack while IN_EMPTY: ignored.
- Output FSM:
  - OUT_IDLE: is_ready_2=1. On dor_write:
    - disp_data <= data_output.
    - counter <= HOLD_CYCLES-1.
    - Move to OUT_HOLD, so disp_busy=1 and is_ready_2=0 from the next cycle.
  - OUT_HOLD: counter decrements each cycle. When the counter is 0, return to OUT_IDLE on that edge. disp_busy is therefore high for exactly HOLD_CYCLES cycles.
  - dor_write during OUT_HOLD: ignored, out_drop set; disp_data and counter unchanged.
  - disp_data holds its value after the hold period ends, until the next accepted write.
- Sticky flags:
  - err_clr clears both flags.
  - If err_clr and a new error occur in the same cycle, the flag ends set (set wins).
- The input and output paths are fully independent; simultaneous events on both paths are handled in the same cycle.

Optional Feature:
Macro: IO_IN_FIFO_EN.
- Defined: the input register is replaced by a FIFO_DEPTH-entry FIFO.
  - Read and write pointers are one bit wider than the address and wrap around.
  - is_ready_1 = not empty. data_input = head entry, registered, and updated on the cycle after a push into an empty FIFO or after a pop.
  - dev_in_strobe when full: word dropped, in_overrun set.
  - in_ack pops one entry; in_ack when empty is ignored.
  - Push and pop in the same cycle when full: both succeed, no overrun.
- Not defined: single-register behaviour as above.

Test Plan:
- Reset: assert rst asynchronously mid-hold, with counter=3 and is_ready_1=1 -> all outputs return to reset values in the same cycle; is_ready_2=1.
- Input handshake: strobe with 0x0000_00A5 -> next cycle is_ready_1=1 and data_input=0x0000_00A5; in_ack -> is_ready_1=0; a second in_ack while empty causes no change.
- Overrun: while IN_FULL with 0x11, strobe 0x22 -> data_input stays 0x11 and in_overrun=1; strobe 0x33 with simultaneous in_ack -> data_input=0x33 and is_ready_1=1; err_clr -> in_overrun=0.
- Output hold (HOLD_CYCLES=4): dor_write with 0xDEAD_BEEF -> disp_data=0xDEADBEEF and disp_busy high for exactly 4 cycles; is_ready_2 low for the same 4 cycles; a dor_write with 0x1234 at hold cycle 2 leaves disp_data=0xDEADBEEF and sets out_drop=1.
- FIFO (IO_IN_FIFO_EN, FIFO_DEPTH=4): strobe 1,2,3,4,5 -> 5 is dropped and in_overrun=1; four in_ack pulses return 1,2,3,4 in order; is_ready_1=0 after the fourth pop.
- Concurrency: in one cycle, strobe 0x7, dor_write 0x9 and err_clr with a new drop -> data_input=0x7, disp_data=0x9, out_drop ends set.
